// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, debug-loaded instruction memory and IF/ID register with run/halt/step control.
// Define IF_PERF_CNT_EN to add the cycle_cnt/fetch_cnt performance counter ports.
module instruction_fetch #(
   parameter int          IMEM_DEPTH  = 256,
   parameter logic [5:0]  HALT_OPCODE = 6'b111111,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_en,
   input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
   input  logic [31:0]                   load_data,
   input  logic                          start,
   input  logic                          step_mode,
   input  logic                          step,
   input  logic                          PC_write,
   input  logic                          IF_ID_write,
   input  logic                          jump_take,
   input  logic [31:0]                   jump_addr,
   input  logic                          branch_take,
   input  logic [31:0]                   branch_addr,
   output logic [31:0]                   outInstruction,
   output logic [31:0]                   outInstructionAddress,
   output logic [31:0]                   outPC,
   output logic                          halted,
   output logic [1:0]                    state
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0]                   cycle_cnt,
   output logic [31:0]                   fetch_cnt
`endif
);
   localparam int AW = $clog2(IMEM_DEPTH);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALT = 2'd3} state_t;
   logic [31:0] imem [IMEM_DEPTH];
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, addr_q, addr_d;
   logic [31:0] rd_word, pc_plus4, target;
   logic        fetch_en, redirect, latch_en;
   assign rd_word  = imem[pc_q[AW+1:2]];
   assign pc_plus4 = pc_q + 32'd4;
   assign fetch_en = (state_q == RUN) || (state_q == STEP && step);
   assign redirect = branch_take || jump_take;
   // the branch is older than the jump in ID, so it wins
   assign target   = branch_take ? branch_addr : jump_addr;
   assign latch_en = fetch_en && !redirect && IF_ID_write;
   always_ff @(posedge clk) begin
      if (state_q == IDLE && load_en) imem[load_addr] <= load_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
      end
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      if (state_q == IDLE && start) state_d = step_mode ? STEP : RUN;
      if (state_q == HALT) begin
         instr_d = '0;
         addr_d  = '0;
      end else if (fetch_en && redirect) begin
         pc_d    = target;
         instr_d = '0;
         addr_d  = '0;
      end else if (fetch_en) begin
         pc_d = PC_write ? pc_plus4 : pc_q;
         if (IF_ID_write) begin
            instr_d = rd_word;
            addr_d  = pc_plus4;
            state_d = (rd_word[31:26] == HALT_OPCODE) ? HALT : state_q;
         end
      end
   end
   assign outInstruction        = instr_q;
   assign outInstructionAddress = addr_q;
   assign outPC                 = pc_q;
   assign halted                = (state_q == HALT);
   assign state                 = state_q;
`ifdef IF_PERF_CNT_EN
   logic [31:0] cycle_q, fetch_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
         fetch_q <= '0;
      end else begin
         if ((state_q == RUN || state_q == STEP) && cycle_q != '1) cycle_q <= cycle_q + 32'd1;
         if (latch_en && fetch_q != '1) fetch_q <= fetch_q + 32'd1;
      end
   end
   assign cycle_cnt = cycle_q;
   assign fetch_cnt = fetch_q;
`else
   logic unused_latch;
   assign unused_latch = latch_en;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven and hand-written sequences checked through an expected-value queue.
module tb_instruction_fetch;
   logic        clk = 1'b0;
   logic        rst, load_en, start, step_mode, step, PC_write, IF_ID_write;
   logic        jump_take, branch_take;
   logic [7:0]  load_addr;
   logic [31:0] load_data, jump_addr, branch_addr;
   logic [31:0] outInstruction, outInstructionAddress, outPC;
   logic        halted;
   logic [1:0]  state;
`ifdef IF_PERF_CNT_EN
   logic [31:0] cycle_cnt, fetch_cnt;
`endif
   int errors = 0;
   int checks = 0;
   typedef struct {
      logic [31:0] pc, instr, addr;
      logic [1:0]  st;
   } exp_t;
   typedef struct {
      logic        pcw, ifw, jt, bt, ld;
      logic [31:0] ja, ba;
      exp_t        e;
   } vec_t;
   exp_t sb[$];
   vec_t tbl[25];
   instruction_fetch dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(start), .step_mode(step_mode), .step(step), .PC_write(PC_write),
      .IF_ID_write(IF_ID_write), .jump_take(jump_take), .jump_addr(jump_addr),
      .branch_take(branch_take), .branch_addr(branch_addr), .outInstruction(outInstruction),
      .outInstructionAddress(outInstructionAddress), .outPC(outPC), .halted(halted), .state(state)
`ifdef IF_PERF_CNT_EN
     ,.cycle_cnt(cycle_cnt), .fetch_cnt(fetch_cnt)
`endif
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] w(input int k);
      return 32'h2000_0000 + k;
   endfunction
   function automatic exp_t ex(input logic [31:0] p, i, a, input logic [1:0] s);
      exp_t e;
      e.pc = p; e.instr = i; e.addr = a; e.st = s;
      return e;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cyc(input string tag, input exp_t e);
      exp_t g;
      sb.push_back(e);
      tick();
      g = sb.pop_front();
      chk({tag, ".pc"}, outPC, g.pc);
      chk({tag, ".instr"}, outInstruction, g.instr);
      chk({tag, ".addr"}, outInstructionAddress, g.addr);
      chk({tag, ".state"}, {30'd0, state}, {30'd0, g.st});
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, g.st == 2'd3});
   endtask
   task automatic idle_in();
      load_en = 0; start = 0; step = 0; jump_take = 0; branch_take = 0;
      PC_write = 1; IF_ID_write = 1;
   endtask
   task automatic load(input int a, input logic [31:0] d);
      load_en = 1; load_addr = a[7:0]; load_data = d;
      tick();
      load_en = 0;
   endtask
   function automatic vec_t row(input logic pcw, ifw, jt, bt, ld, input logic [31:0] ja, ba, p, i, a);
      vec_t v;
      v.pcw = pcw; v.ifw = ifw; v.jt = jt; v.bt = bt; v.ld = ld; v.ja = ja; v.ba = ba;
      v.e = ex(p, i, a, 2'd1);
      return v;
   endfunction
   initial begin
      rst = 1; step_mode = 0; load_addr = 0; load_data = 0; jump_addr = 0; branch_addr = 0;
      idle_in();
      tbl[0]  = row(1, 1, 0, 0, 0, 0, 0, 32'h4, w(0), 32'h4);
      tbl[1]  = row(1, 1, 0, 0, 0, 0, 0, 32'h8, w(1), 32'h8);
      tbl[2]  = row(0, 0, 0, 0, 0, 0, 0, 32'h8, w(1), 32'h8);
      tbl[3]  = row(0, 0, 0, 0, 0, 0, 0, 32'h8, w(1), 32'h8);
      tbl[4]  = row(1, 1, 0, 0, 0, 0, 0, 32'hC, w(2), 32'hC);
      tbl[5]  = row(1, 1, 0, 0, 0, 0, 0, 32'h10, w(3), 32'h10);
      tbl[6]  = row(1, 1, 1, 0, 0, 32'h40, 0, 32'h40, 0, 0);
      tbl[7]  = row(1, 1, 0, 0, 0, 0, 0, 32'h44, w(16), 32'h44);
      tbl[8]  = row(0, 0, 1, 1, 0, 32'h40, 32'h80, 32'h80, 0, 0);
      tbl[9]  = row(1, 1, 0, 0, 0, 0, 0, 32'h84, w(32), 32'h84);
      tbl[10] = row(1, 0, 0, 0, 0, 0, 0, 32'h88, w(32), 32'h84);
      tbl[11] = row(0, 1, 0, 0, 0, 0, 0, 32'h88, w(34), 32'h8C);
      tbl[12] = row(1, 1, 0, 1, 0, 0, 32'h400, 32'h400, 0, 0);
      tbl[13] = row(1, 1, 0, 0, 0, 0, 0, 32'h404, w(0), 32'h404);
      tbl[14] = row(1, 1, 1, 0, 0, 32'h1D, 0, 32'h1D, 0, 0);
      tbl[15] = row(1, 1, 0, 0, 0, 0, 0, 32'h21, w(7), 32'h21);
      tbl[16] = row(1, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
      tbl[17] = row(1, 1, 0, 0, 0, 0, 0, 32'h0, w(255), 32'h0);
      for (int i = 0; i < 7; i++) tbl[18+i] = row(1, 1, 0, 0, i == 5, 0, 0, 4*(i+1), w(i), 4*(i+1));
      tick();
      cyc("reset", ex(0, 0, 0, 0));
      rst = 0;
      load(0, 32'h2001_0005); load(1, 32'h2002_0007); load(2, 32'hFC00_0000);
      start = 1;
      cyc("a_start", ex(0, 0, 0, 1));
      start = 0;
      cyc("a_e1", ex(32'h4, 32'h2001_0005, 32'h4, 1));
      cyc("a_e2", ex(32'h8, 32'h2002_0007, 32'h8, 1));
      cyc("a_e3", ex(32'hC, 32'hFC00_0000, 32'hC, 3));
      cyc("a_drain", ex(32'hC, 0, 0, 3));
      branch_take = 1; branch_addr = 32'h80;
      cyc("a_halt_redirect", ex(32'hC, 0, 0, 3));
      branch_take = 0;
      rst = 1;
      cyc("b_reset", ex(0, 0, 0, 0));
      rst = 0;
      for (int k = 0; k < 256; k++) load(k, w(k));
      start = 1;
      cyc("b_start", ex(0, 0, 0, 1));
      start = 0;
      for (int i = 0; i < 25; i++) begin
         PC_write = tbl[i].pcw; IF_ID_write = tbl[i].ifw;
         jump_take = tbl[i].jt; jump_addr = tbl[i].ja;
         branch_take = tbl[i].bt; branch_addr = tbl[i].ba;
         load_en = tbl[i].ld; load_addr = 8'd2; load_data = 32'hFC00_0000;
         cyc($sformatf("b_row%0d", i), tbl[i].e);
      end
      idle_in();
      rst = 1;
      cyc("c_reset", ex(0, 0, 0, 0));
      rst = 0; jump_take = 1; jump_addr = 32'h40;
      cyc("c_idle_redirect", ex(0, 0, 0, 0));
      jump_take = 0; start = 1;
      cyc("c_start", ex(0, 0, 0, 1));
      start = 0;
      cyc("c_e1", ex(32'h4, w(0), 32'h4, 1));
      cyc("c_e2", ex(32'h8, w(1), 32'h8, 1));
      cyc("c_e3_noload", ex(32'hC, w(2), 32'hC, 1));
      rst = 1;
      cyc("d_reset", ex(0, 0, 0, 0));
      rst = 0; step_mode = 1; start = 1;
      cyc("d_start", ex(0, 0, 0, 2));
      start = 0;
      for (int c = 1; c <= 8; c++) begin
         step = (c == 3 || c == 7);
         jump_take = (c == 5); jump_addr = 32'h40;
         cyc($sformatf("d_step%0d", c),
             ex(c >= 7 ? 32'h8 : (c >= 3 ? 32'h4 : 32'h0),
                c >= 7 ? w(1) : (c >= 3 ? w(0) : 32'h0),
                c >= 7 ? 32'h8 : (c >= 3 ? 32'h4 : 32'h0), 2));
      end
      idle_in();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
